// File: rtl/mux_generate_pkg.sv
// Shared constants and helpers for the four-way generate-tree multiplexer.
package mux_generate_pkg;

    localparam int SEL_W = 2;
    localparam int N_IN  = 2**SEL_W;

    localparam logic [N_IN-1:0] RESET_OH = 4'b0001;

    function automatic logic [N_IN-1:0] onehot4(input logic [SEL_W-1:0] sel);
        return N_IN'(1) << sel;
    endfunction

endpackage

// File: rtl/mux_generate_mux2_cell.sv
// Bitwise 2:1 selector cell used as the building block of the mux tree.
module mux2_cell #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] out
);

    assign out = s ? b : a;

endmodule

// File: rtl/mux_generate.sv
// Four-input mux built as a tree of 2:1 cells, with a registered copy of the
// output and a registered one-hot decode of the select.
module mux_generate
    import mux_generate_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [N_IN-1:0]  sel_oh_q
);

    // Flattened tree: leaves at 0..N_IN-1, each level's outputs appended after
    // its inputs, root in the last slot.
    logic [WIDTH-1:0] tree [0:2*N_IN-2];

    assign tree[0] = i0;
    assign tree[1] = i1;
    assign tree[2] = i2;
    assign tree[3] = i3;

    genvar lvl, n;
    generate
        for (lvl = 0; lvl < SEL_W; lvl++) begin : g_level
            localparam int IN_BASE  = 2*N_IN - 2*(N_IN >> lvl);
            localparam int OUT_BASE = 2*N_IN - 2*(N_IN >> (lvl + 1));
            for (n = 0; n < (N_IN >> (lvl + 1)); n++) begin : g_node
                mux2_cell #(
                    .WIDTH (WIDTH)
                ) u_cell (
                    .a   (tree[IN_BASE + 2*n]),
                    .b   (tree[IN_BASE + 2*n + 1]),
                    .s   (sel[lvl]),
                    .out (tree[OUT_BASE + n])
                );
            end
        end
    endgenerate

    assign y = tree[2*N_IN-2];

    logic [WIDTH-1:0] y_d;
    logic [N_IN-1:0]  sel_oh_d;

    always_comb begin
        y_d      = y;
        sel_oh_d = onehot4(sel);
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q      <= '0;
            sel_oh_q <= RESET_OH;
        end else begin
            y_q      <= y_d;
            sel_oh_q <= sel_oh_d;
        end
    end

endmodule

// File: tb/tb_mux_generate.sv
// Scoreboard bench for mux_generate: an 8-bit and a 1-bit instance share stimulus.
module tb_mux_generate;

    typedef enum logic [2:0] {K_Y, K_YQ, K_OH, K_Y1, K_YQ1} kind_e;

    typedef struct {
        kind_e      kind;
        logic [7:0] exp;
        string      tag;
    } sb_item_t;

    logic       clk = 1'b0;
    bit         clk_en = 1'b0;
    logic       reset;
    logic [1:0] sel;
    logic [7:0] i0, i1, i2, i3;
    logic [7:0] y, y_q;
    logic [3:0] sel_oh_q;
    logic       y1, y1_q;
    logic [3:0] sel_oh1_q;

    sb_item_t sb_q[$];
    event     sample_ev;
    int       n_cmp = 0;
    int       n_err = 0;

    always #5 if (clk_en) clk = ~clk;

    mux_generate #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .sel      (sel),
        .i0       (i0),
        .i1       (i1),
        .i2       (i2),
        .i3       (i3),
        .y        (y),
        .y_q      (y_q),
        .sel_oh_q (sel_oh_q)
    );

    mux_generate dut_w1 (
        .clk      (clk),
        .reset    (reset),
        .sel      (sel),
        .i0       (i0[0]),
        .i1       (i1[0]),
        .i2       (i2[0]),
        .i3       (i3[0]),
        .y        (y1),
        .y_q      (y1_q),
        .sel_oh_q (sel_oh1_q)
    );

    function automatic logic [7:0] pick(input logic [1:0] s);
        case (s)
            2'd0:    return i0;
            2'd1:    return i1;
            2'd2:    return i2;
            default: return i3;
        endcase
    endfunction

    function automatic logic [3:0] oh_of(input logic [1:0] s);
        case (s)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0010;
            2'd2:    return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic push(input kind_e k, input logic [7:0] e, input string tag);
        sb_item_t it;
        it.kind = k;
        it.exp  = e;
        it.tag  = tag;
        sb_q.push_back(it);
    endtask

    task automatic expect_y(input string tag);
        logic [7:0] v;
        v = pick(sel);
        push(K_Y, v, tag);
        push(K_Y1, {7'b0, v[0]}, {tag, "_w1"});
    endtask

    task automatic expect_reg(input logic [7:0] yv, input logic [3:0] oh, input string tag);
        push(K_YQ, yv, {tag, "_yq"});
        push(K_OH, {4'b0, oh}, {tag, "_oh"});
        push(K_YQ1, {7'b0, yv[0]}, {tag, "_yq_w1"});
    endtask

    task automatic sample();
        -> sample_ev;
        #1;
    endtask

    // Monitor: drains every pending expectation against the outputs present now.
    initial begin
        sb_item_t   it;
        logic [7:0] act;
        forever begin
            @(sample_ev);
            while (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                case (it.kind)
                    K_Y:     act = y;
                    K_YQ:    act = y_q;
                    K_OH:    act = {4'b0, sel_oh_q};
                    K_Y1:    act = {7'b0, y1};
                    default: act = {7'b0, y1_q};
                endcase
                n_cmp++;
                if (act !== it.exp) begin
                    n_err++;
                    $display("FAIL %s: got %0h expected %0h at %0t", it.tag, act, it.exp, $time);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] hold_y;
        logic [3:0] hold_oh;

        // Reset pulse with the clock idle.
        reset = 1'b1;
        sel   = 2'd0;
        i0 = 8'hA5; i1 = 8'h5A; i2 = 8'h3C; i3 = 8'hC3;
        #1;
        expect_y("rst_y_early");
        expect_reg(8'h00, 4'b0001, "rst_early");
        sample();
        #7;
        expect_y("rst_y_late");
        expect_reg(8'h00, 4'b0001, "rst_late");
        sample();
        reset = 1'b0;

        // Select sweep: inputs change at different rates, y must track i[sel].
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            for (int k = 1; k <= 8; k++) begin
                i0 = ~i0;
                if (k % 2 == 0) i1 = i1 + 8'h13;
                if (k % 3 == 0) i2 = i2 ^ 8'h0F;
                if (k % 5 == 0) i3 = ~i3;
                #4;
                expect_y($sformatf("sweep_s%0d_k%0d", s, k));
                sample();
            end
        end

        // Counter-driven select with the clock running.
        i0 = 8'h11; i1 = 8'h22; i2 = 8'h33; i3 = 8'h44;
        sel = 2'd0;
        #1;
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        expect_reg(8'h11, 4'b0001, "first_edge");
        sample();
        for (int k = 0; k < 8; k++) begin
            sel = sel + 2'd1;
            expect_y($sformatf("cnt_y_%0d", k));
            sample();
            hold_y  = pick(sel);
            hold_oh = oh_of(sel);
            @(posedge clk);
            #1;
            expect_reg(hold_y, hold_oh, $sformatf("cnt_reg_%0d", k));
            sample();
        end

        // Registered path: y drops at once, y_q waits for the edge.
        sel = 2'd2;
        i2  = 8'h01;
        @(posedge clk);
        #1;
        expect_reg(8'h01, 4'b0100, "regpath_capture");
        sample();
        i2 = 8'h00;
        expect_y("regpath_y_drop");
        push(K_YQ, 8'h01, "regpath_yq_hold");
        sample();
        @(posedge clk);
        #1;
        expect_reg(8'h00, 4'b0100, "regpath_next_edge");
        sample();

        // Asynchronous reset between edges.
        i2 = 8'h01;
        @(posedge clk);
        #1;
        expect_reg(8'h01, 4'b0100, "arst_before");
        sample();
        reset = 1'b1;
        #1;
        expect_reg(8'h00, 4'b0001, "arst_immediate");
        expect_y("arst_y_unaffected");
        sample();
        @(posedge clk);
        #1;
        expect_reg(8'h00, 4'b0001, "arst_held");
        sample();
        reset = 1'b0;
        @(posedge clk);
        #1;
        expect_reg(8'h01, 4'b0100, "arst_reload");
        sample();

        // Select and data change in the same cycle.
        sel = 2'd3;
        i3  = 8'h77;
        expect_y("same_cycle_y");
        sample();
        @(posedge clk);
        #1;
        expect_reg(8'h77, 4'b1000, "same_cycle_reg");
        sample();

        // All inputs equal, hand-computed constant for every select.
        i0 = 8'h5E; i1 = 8'h5E; i2 = 8'h5E; i3 = 8'h5E;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            push(K_Y, 8'h5E, $sformatf("equal_s%0d", s));
            sample();
        end

        // Distinct byte sources, hand-computed expectations.
        i0 = 8'h11; i1 = 8'h22; i2 = 8'h33; i3 = 8'h44;
        sel = 2'd0; #1; push(K_Y, 8'h11, "w8_s0"); sample();
        sel = 2'd1; #1; push(K_Y, 8'h22, "w8_s1"); sample();
        sel = 2'd2; #1; push(K_Y, 8'h33, "w8_s2"); sample();
        sel = 2'd3; #1; push(K_Y, 8'h44, "w8_s3"); sample();

        #2;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
